// File: rtl/sap_control_sequencer.sv
// ============================================================================
// Module  : sap_control_sequencer
// Purpose : Microprogrammed control unit for the SAP-BR 8-bit CPU. Steps the
//           fetch (T1-T3) and execute (T4-T6) T-states, decodes the IR
//           opcode and drives the active-low W-bus load/output enables.
//           Optional single-step support is compiled in when the macro
//           SAP_SINGLE_STEP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_control_sequencer #(
    parameter bit         EARLY_END = 1'b1,
    parameter logic [3:0] OP_LDA    = 4'h0,
    parameter logic [3:0] OP_ADD    = 4'h1,
    parameter logic [3:0] OP_SUB    = 4'h2,
    parameter logic [3:0] OP_OUT    = 4'hE,
    parameter logic [3:0] OP_HLT    = 4'hF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] IR_OPCODE,
`ifdef SAP_SINGLE_STEP_EN
    input  logic       STEP_MODE,
    input  logic       STEP,
`endif
    output logic       PC_INC,
    output logic       _EN_PC_OUT,
    output logic       _EN_MAR_IN,
    output logic       _EN_RAM_OUT,
    output logic       _EN_IR_IN,
    output logic       _EN_IR_OUT,
    output logic       _EN_ACC_IN,
    output logic       _EN_ACC_OUT,
    output logic       _EN_B_IN,
    output logic       ULA_SUB,
    output logic       _EN_ULA_OUT,
    output logic       _EN_OUT_IN,
    output logic       HALT,
    output logic [2:0] T_STATE
);

    // State encoding doubles as the T_STATE value (HALTED reads as 0).
    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_T1     = 3'd1,
        S_T2     = 3'd2,
        S_T3     = 3'd3,
        S_T4     = 3'd4,
        S_T5     = 3'd5,
        S_T6     = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_advance;

`ifdef SAP_SINGLE_STEP_EN
    logic [1:0] r_step_sync;
    logic       r_step_prev;

    // Synchronise the STEP button and remember its last value for edge detect.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_step_sync <= 2'b00;
            r_step_prev <= 1'b0;
        end else begin
            r_step_sync <= {r_step_sync[0], STEP};
            r_step_prev <= r_step_sync[1];
        end
    end

    assign w_advance = ~STEP_MODE | (r_step_sync[1] & ~r_step_prev);
`else
    assign w_advance = 1'b1;
`endif

    // Next-state selection; early return to T1 skips trailing idle microsteps.
    always_comb begin
        w_next_state = S_T1;
        case (r_state)
            S_T1: w_next_state = S_T2;
            S_T2: w_next_state = S_T3;
            S_T3: w_next_state = S_T4;
            S_T4: begin
                if (IR_OPCODE == OP_HLT) begin
                    w_next_state = S_HALTED;
                end else if (IR_OPCODE == OP_LDA || IR_OPCODE == OP_ADD ||
                             IR_OPCODE == OP_SUB) begin
                    w_next_state = S_T5;
                end else begin
                    w_next_state = EARLY_END ? S_T1 : S_T5;
                end
            end
            S_T5: begin
                if (IR_OPCODE == OP_LDA) begin
                    w_next_state = EARLY_END ? S_T1 : S_T6;
                end else begin
                    w_next_state = S_T6;
                end
            end
            S_T6:     w_next_state = S_T1;
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_T1;
        endcase
    end

    // State register; HALTED is left only through RESET.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_T1;
        end else if (w_advance) begin
            r_state <= w_next_state;
        end
    end

    assign HALT    = (r_state == S_HALTED);
    assign T_STATE = r_state;

    // Control word decode; forced idle during RESET and non-stepping cycles
    // so that no datapath register loads and no bus driver is enabled.
    always_comb begin
        PC_INC      = 1'b0;
        _EN_PC_OUT  = 1'b1;
        _EN_MAR_IN  = 1'b1;
        _EN_RAM_OUT = 1'b1;
        _EN_IR_IN   = 1'b1;
        _EN_IR_OUT  = 1'b1;
        _EN_ACC_IN  = 1'b1;
        _EN_ACC_OUT = 1'b1;
        _EN_B_IN    = 1'b1;
        ULA_SUB     = 1'b0;
        _EN_ULA_OUT = 1'b1;
        _EN_OUT_IN  = 1'b1;
        if (!RESET && w_advance) begin
            case (r_state)
                S_T1: begin
                    _EN_PC_OUT = 1'b0;
                    _EN_MAR_IN = 1'b0;
                end
                S_T2: PC_INC = 1'b1;
                S_T3: begin
                    _EN_RAM_OUT = 1'b0;
                    _EN_IR_IN   = 1'b0;
                end
                S_T4: begin
                    if (IR_OPCODE == OP_LDA || IR_OPCODE == OP_ADD ||
                        IR_OPCODE == OP_SUB) begin
                        _EN_IR_OUT = 1'b0;
                        _EN_MAR_IN = 1'b0;
                    end else if (IR_OPCODE == OP_OUT) begin
                        _EN_ACC_OUT = 1'b0;
                        _EN_OUT_IN  = 1'b0;
                    end
                end
                S_T5: begin
                    if (IR_OPCODE == OP_LDA) begin
                        _EN_RAM_OUT = 1'b0;
                        _EN_ACC_IN  = 1'b0;
                    end else if (IR_OPCODE == OP_ADD || IR_OPCODE == OP_SUB) begin
                        _EN_RAM_OUT = 1'b0;
                        _EN_B_IN    = 1'b0;
                        ULA_SUB     = (IR_OPCODE == OP_SUB);
                    end
                end
                S_T6: begin
                    if (IR_OPCODE == OP_ADD || IR_OPCODE == OP_SUB) begin
                        _EN_ULA_OUT = 1'b0;
                        _EN_ACC_IN  = 1'b0;
                        ULA_SUB     = (IR_OPCODE == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
